spi_byte_feeder: RTL and testbench

// - Downstream partner of the program counter. Fetches memory bytes and shifts them out serially on the SPI data line.
// - Consumes the counter's memAddr and its one-clk 'next' pulse, plus serialClock's sclkPosEdge/sclkNegEdge strobes.
// - Keeps one byte prefetched, so the byte change at each 'next' costs zero sclk periods.

---
 rtl/spi_byte_feeder_pkg.sv | 18 +
 rtl/spi_tx_shreg.sv | 49 ++++
 rtl/spi_byte_feeder.sv | 182 ++++++++++++++++++
 tb/tb_spi_byte_feeder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_feeder_pkg.sv
// Shared definitions for the SPI byte feeder.
// Holds the priming/run FSM encoding and the default byte geometry used by
// spi_byte_feeder and spi_tx_shreg.
package spi_byte_feeder_pkg;

  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam logic [7:0]  FILL_BYTE_DEF = 8'h00;

  // 2-bit FSM: three priming steps, then steady-state streaming.
  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    PRIME2 = 2'd2,
    RUN    = 2'd3
  } feed_state_e;

endpackage

// File: rtl/spi_tx_shreg.sv
// Parallel-load, MSB-first transmit shift register with registered mosi.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load_i         load load_data_i into the register (wins over shift_i)
//   load_data_i    byte to load
//   shift_i        present the MSB on mosi_o and shift left by one
//   mosi_o         registered serial output
module spi_tx_shreg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_i,
  output logic              mosi_o
);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              mosi_q, mosi_d;

  // Next-state: load has priority; a shift moves the MSB to the output pin.
  always_comb begin
    shreg_d = shreg_q;
    mosi_d  = mosi_q;
    if (load_i) begin
      shreg_d = load_data_i;
    end else if (shift_i) begin
      mosi_d  = shreg_q[DATA_W-1];
      shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
    end else begin
      shreg_d = shreg_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      mosi_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      mosi_q  <= mosi_d;
    end
  end

  assign mosi_o = mosi_q;

endmodule

// File: rtl/spi_byte_feeder.sv
// SPI byte feeder: fetches bytes from a synchronous-read memory at the
// addresses supplied by the program counter and streams them MSB first on
// mosi. One byte is kept prefetched so the swap at each 'next' is free.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sclkPosEdge, sclkNegEdge  one-clk serial clock edge strobes
//   shiftEn                   gates shifting (fetching still follows next)
//   memAddr, next             current address and its advance pulse
//   memRdEn, memRdAddr        read request (data returns one clk later)
//   memRdData                 read data
//   mosi                      serial data out
//   ready                     priming complete
//   underrun                  one-clk pulse when next finds no prefetch
//   errCnt                    saturating underrun count (only with
//                             SPI_FEEDER_ERRCNT_EN defined)
// Read requests are issued combinationally in the cycle of the triggering
// state/next so the data can be captured exactly one clk later.
module spi_byte_feeder
  import spi_byte_feeder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FILL_BYTE = DATA_W'(FILL_BYTE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclkPosEdge,
  input  logic              sclkNegEdge,
  input  logic              shiftEn,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic              next,
  output logic              memRdEn,
  output logic [ADDR_W-1:0] memRdAddr,
  input  logic [DATA_W-1:0] memRdData,
  output logic              mosi,
  output logic              ready,
  output logic              underrun
`ifdef SPI_FEEDER_ERRCNT_EN
  ,
  output logic [7:0]        errCnt
`endif
);

  feed_state_e       state_q, state_d;
  logic [DATA_W-1:0] pbuf_q, pbuf_d;
  logic              pbuf_valid_q, pbuf_valid_d;
  logic              cap_due_q, cap_due_d;
  logic              ready_q, ready_d;
  logic              underrun_q, underrun_d;

  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic              load_s;
  logic              shift_s;
  logic [DATA_W-1:0] load_data_s;

  // Prefetch address wraps naturally modulo 2**ADDR_W.
  assign addr_inc_s = memAddr + ADDR_W'(1);

  // FSM next-state, prefetch buffer and read-request decode.
  always_comb begin
    state_d      = state_q;
    pbuf_d       = pbuf_q;
    pbuf_valid_d = pbuf_valid_q;
    cap_due_d    = 1'b0;
    ready_d      = ready_q;
    underrun_d   = 1'b0;
    rd_en_s      = 1'b0;
    rd_addr_s    = addr_inc_s;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    load_data_s  = pbuf_q;
    case (state_q)
      PRIME0: begin
        rd_en_s    = 1'b1;
        rd_addr_s  = memAddr;
        underrun_d = next;
        state_d    = PRIME1;
      end
      PRIME1: begin
        load_s      = 1'b1;
        load_data_s = memRdData;
        rd_en_s     = 1'b1;
        underrun_d  = next;
        state_d     = PRIME2;
      end
      PRIME2: begin
        pbuf_d       = memRdData;
        pbuf_valid_d = 1'b1;
        ready_d      = 1'b1;
        underrun_d   = next;
        state_d      = RUN;
      end
      RUN: begin
        if (next) begin
          // Load beats a coincident negedge strobe.
          load_s       = 1'b1;
          load_data_s  = pbuf_valid_q ? pbuf_q : FILL_BYTE;
          underrun_d   = ~pbuf_valid_q;
          pbuf_valid_d = 1'b0;
          rd_en_s      = 1'b1;
          cap_due_d    = 1'b1;
        end else begin
          shift_s = shiftEn & sclkNegEdge;
        end
        // A pending capture is always taken, even if next just cleared valid.
        if (cap_due_q) begin
          pbuf_d       = memRdData;
          pbuf_valid_d = 1'b1;
        end else begin
          pbuf_d = pbuf_d;
        end
      end
      default: begin
        state_d = PRIME0;
      end
    endcase
  end

  // FSM and prefetch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PRIME0;
      pbuf_q       <= '0;
      pbuf_valid_q <= 1'b0;
      cap_due_q    <= 1'b0;
      ready_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pbuf_q       <= pbuf_d;
      pbuf_valid_q <= pbuf_valid_d;
      cap_due_q    <= cap_due_d;
      ready_q      <= ready_d;
      underrun_q   <= underrun_d;
    end
  end

  // Hold the read port idle while reset is asserted.
  assign memRdEn   = rd_en_s & ~rst;
  assign memRdAddr = rst ? '0 : rd_addr_s;
  assign ready     = ready_q;
  assign underrun  = underrun_q;

  spi_tx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_s),
    .load_data_i (load_data_s),
    .shift_i     (shift_s),
    .mosi_o      (mosi)
  );

`ifdef SPI_FEEDER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count, updated together with the underrun pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (underrun_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign errCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_byte_feeder.sv
module tb_spi_byte_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclkPosEdge, sclkNegEdge, shiftEn, next;
  logic [15:0] memAddr;
  logic        memRdEn;
  logic [15:0] memRdAddr;
  logic [7:0]  memRdData = 8'h00;
  logic        mosi, ready, underrun;
`ifdef SPI_FEEDER_ERRCNT_EN
  logic [7:0]  errCnt;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx;
  int          nbits;
  int          ph;
  int          bytes_done;
  logic        model_on;

  always #5 clk = ~clk;

  spi_byte_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .sclkPosEdge (sclkPosEdge),
    .sclkNegEdge (sclkNegEdge),
    .shiftEn     (shiftEn),
    .memAddr     (memAddr),
    .next        (next),
    .memRdEn     (memRdEn),
    .memRdAddr   (memRdAddr),
    .memRdData   (memRdData),
    .mosi        (mosi),
    .ready       (ready),
    .underrun    (underrun)
`ifdef SPI_FEEDER_ERRCNT_EN
    ,
    .errCnt      (errCnt)
`endif
  );

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Synchronous 1-clk read memory.
  always @(posedge clk) begin
    if (memRdEn) memRdData <= mem_f(memRdAddr);
  end

  // One clk of the serial-clock / program-counter model; collects bits on
  // posedge strobes and compares each completed byte with the scoreboard.
  task automatic tick();
    logic [7:0] e;
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    next        = 1'b0;
    if (model_on) begin
      if (ph == 0) sclkNegEdge = 1'b1;
      if (ph == 2) begin
        sclkPosEdge = 1'b1;
        if (shiftEn) begin
          rx    = {rx[6:0], mosi};
          nbits = nbits + 1;
          if (nbits == 8) begin
            nbits   = 0;
            next    = 1'b1;
            memAddr = memAddr + 16'd1;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL byte_no_expect: got %h required none", rx);
            end else begin
              e = exp_q.pop_front();
              if (rx !== e) begin
                failures++;
                $display("FAIL byte_stream: got %h required %h", rx, e);
              end
            end
            exp_q.push_back(mem_f(memAddr));
            bytes_done++;
          end
        end
      end
      ph = (ph + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_prime(input logic [15:0] addr, input logic start_model);
    rst = 1'b1; model_on = 1'b0; shiftEn = 1'b1; next = 1'b0;
    sclkPosEdge = 1'b0; sclkNegEdge = 1'b0;
    memAddr = addr; exp_q.delete(); nbits = 0; ph = 0; rx = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) tick();
    if (start_model) begin
      exp_q.push_back(mem_f(addr));
      model_on = 1'b1;
    end
  endtask

  task automatic run_bytes(input int n, input string name);
    int target;
    target = bytes_done + n;
    for (int i = 0; i < n * 40 + 40; i++) begin
      if (bytes_done >= target) break;
      tick();
    end
    checks++;
    if (bytes_done < target) begin
      failures++;
      $display("FAIL %s_timeout: got %0d bytes required %0d", name, bytes_done, target);
    end
  endtask

  task automatic wait_bits(input int n, input string name);
    for (int i = 0; i < 200; i++) begin
      if (nbits == n && ph == 1) break;
      tick();
    end
    checks++;
    if (!(nbits == n && ph == 1)) begin
      failures++;
      $display("FAIL %s_wait: got %0d bits required %0d", name, nbits, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; model_on = 1'b0; shiftEn = 1'b1; next = 1'b0;
    sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; memAddr = 16'h0000;
    exp_q.delete(); nbits = 0; ph = 0; rx = 8'h00; bytes_done = 0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({mosi, memRdEn, ready, underrun} !== 4'b0000 || memRdAddr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_values: got mosi=%b en=%b rdy=%b ur=%b addr=%h required all 0",
               mosi, memRdEn, ready, underrun, memRdAddr);
    end
`ifdef SPI_FEEDER_ERRCNT_EN
    checks++;
    if (errCnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_errcnt: got %h required 00", errCnt);
    end
`endif
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ready !== (i == 3)) begin
        failures++;
        $display("FAIL ready_latency: clk %0d got %b required %b", i, ready, (i == 3));
      end
    end
  endtask

  task automatic test_basic();
    exp_q.push_back(mem_f(16'h0000));
    model_on = 1'b1;
    run_bytes(3, "basic");
  endtask

  task automatic test_wrap();
    rst = 1'b1; model_on = 1'b0; memAddr = 16'hFFFF;
    exp_q.delete(); nbits = 0; ph = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    checks++;
    if (memRdEn !== 1'b1 || memRdAddr !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_rdaddr: got en=%b addr=%h required 1 0000", memRdEn, memRdAddr);
    end
    repeat (2) tick();
    exp_q.push_back(mem_f(16'hFFFF));
    model_on = 1'b1;
    run_bytes(2, "wrap");
  endtask

  task automatic test_underrun();
    do_prime(16'h0020, 1'b0);
    next = 1'b1; memAddr = memAddr + 16'd1;
    @(posedge clk); #1;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_first: got %b required 0", underrun);
    end
    next = 1'b1; memAddr = memAddr + 16'd1;
    @(posedge clk); #1;
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_pulse: got %b required 1", underrun);
    end
    next = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_width: got %b required 0", underrun);
    end
`ifdef SPI_FEEDER_ERRCNT_EN
    checks++;
    if (errCnt !== 8'h01) begin
      failures++;
      $display("FAIL underrun_errcnt: got %h required 01", errCnt);
    end
`endif
    exp_q.delete();
    exp_q.push_back(8'h00);
    nbits = 0; ph = 0; model_on = 1'b1;
    run_bytes(2, "underrun");
  endtask

  task automatic test_pause();
    logic hold;
    do_prime(16'h0040, 1'b1);
    wait_bits(3, "pause");
    hold = mosi;
    shiftEn = 1'b0;
    repeat (52) tick();
    checks++;
    if (mosi !== hold) begin
      failures++;
      $display("FAIL pause_hold: got %b required %b", mosi, hold);
    end
    shiftEn = 1'b1;
    run_bytes(2, "pause");
  endtask

  task automatic test_midbyte_reset();
    do_prime(16'h0008, 1'b1);
    wait_bits(4, "rstmid");
    rst = 1'b1;
    #1;
    checks++;
    if (mosi !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_values: got mosi=%b ready=%b required 0 0", mosi, ready);
    end
    do_prime(memAddr, 1'b1);
    run_bytes(2, "rstmid");
  endtask

`ifdef SPI_FEEDER_ERRCNT_EN
  task automatic test_saturation();
    do_prime(16'h0100, 1'b0);
    for (int i = 0; i < 700; i++) begin
      next = 1'b1; memAddr = memAddr + 16'd1;
      @(posedge clk); #1;
    end
    next = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (errCnt !== 8'hFF) begin
      failures++;
      $display("FAIL errcnt_saturate: got %h required ff", errCnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_underrun();
    test_pause();
    test_midbyte_reset();
`ifdef SPI_FEEDER_ERRCNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
